// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, parity modes,
// and the parity helper used when a word is accepted.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Parity bit for a word of up to 9 bits; zero-extension does not change the XOR.
  function automatic logic parity_of(input logic [8:0] data, input int mode);
    logic p;
    p = ^data;
    case (mode)
      PAR_EVEN: return p;
      PAR_ODD:  return ~p;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps at the terminal value,
// and flags the last clock of each serial bit.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             bit_end
);

  logic [CNT_W-1:0] count_r;

  assign bit_end = (count_r == CNT_W'(CLKS_PER_BIT - 1));
  assign count   = count_r;

  // Advance the bit-period count; hold at zero while cleared, wrap after the last clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (bit_end) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one word per valid/ready handshake, framed as
// start / data (LSB first) / optional parity / 1-2 stop bits.
// All outputs are registered from next-state values so the line is glitch-free.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              serial_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W);

  generate
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_width
      $error("uart_tx_frame: DATA_W must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
      $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
  endgenerate

  uart_state_t       state_r, state_nxt_s;
  logic [DATA_W-1:0] shift_r, shift_nxt_s;
  logic              par_r, par_nxt_s;
  logic [IDX_W-1:0]  idx_r, idx_nxt_s;
  logic              serial_out_r, serial_nxt_s;
  logic              tx_ready_r, busy_r;
  logic              frame_done_r, frame_done_nxt_s;
  logic [CNT_W-1:0]  cnt_s;
  logic              bit_end_s;
  logic              clr_s;

  // The counter only runs inside a frame; every later state entry lands on a wrap.
  assign clr_s = (state_r == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_s),
    .count   (cnt_s),
    .bit_end (bit_end_s)
  );

  // Next-state, shift/parity/index updates and next line level.
  always_comb begin
    state_nxt_s      = state_r;
    shift_nxt_s      = shift_r;
    par_nxt_s        = par_r;
    idx_nxt_s        = idx_r;
    serial_nxt_s     = 1'b1;
    frame_done_nxt_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (tx_valid && tx_ready_r) begin
          state_nxt_s = START;
          shift_nxt_s = tx_data;
          par_nxt_s   = parity_of(9'(tx_data), PARITY_MODE);
          idx_nxt_s   = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_nxt_s = DATA;
          idx_nxt_s   = '0;
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_nxt_s = shift_r >> 1;
          if (idx_r == IDX_W'(DATA_W - 1)) begin
            state_nxt_s = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
            idx_nxt_s   = '0;
          end else begin
            idx_nxt_s   = idx_r + IDX_W'(1);
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          state_nxt_s = STOP;
          idx_nxt_s   = '0;
        end else begin
          state_nxt_s = PARITY;
        end
      end
      STOP: begin
        // Look one clock ahead so the registered pulse lands in the final stop clock.
        if ((idx_r == IDX_W'(STOP_BITS - 1)) && (cnt_s == CNT_W'(CLKS_PER_BIT - 2))) begin
          frame_done_nxt_s = 1'b1;
        end else begin
          frame_done_nxt_s = 1'b0;
        end
        if (bit_end_s) begin
          if (idx_r == IDX_W'(STOP_BITS - 1)) begin
            state_nxt_s = IDLE;
            idx_nxt_s   = '0;
          end else begin
            idx_nxt_s   = idx_r + IDX_W'(1);
          end
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        idx_nxt_s   = '0;
      end
    endcase

    case (state_nxt_s)
      START:   serial_nxt_s = 1'b0;
      DATA:    serial_nxt_s = shift_nxt_s[0];
      PARITY:  serial_nxt_s = par_nxt_s;
      default: serial_nxt_s = 1'b1;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      shift_r      <= '0;
      par_r        <= 1'b0;
      idx_r        <= '0;
      serial_out_r <= 1'b1;
      tx_ready_r   <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      shift_r      <= shift_nxt_s;
      par_r        <= par_nxt_s;
      idx_r        <= idx_nxt_s;
      serial_out_r <= serial_nxt_s;
      tx_ready_r   <= (state_nxt_s == IDLE);
      busy_r       <= (state_nxt_s != IDLE);
      frame_done_r <= frame_done_nxt_s;
    end
  end

  assign tx_ready   = tx_ready_r;
  assign busy       = busy_r;
  assign serial_out = serial_out_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: four configurations side by side, each frame
// compared clock by clock against a bit list built from the framing rules.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, v1, v2, v3;
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic       so0, so1, so2, so3;
  logic       rd0, rd1, rd2, rd3;
  logic       bs0, bs1, bs2, bs3;
  logic       fd0, fd1, fd2, fd3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 0: defaults (8E1 @16)  1: odd parity  2: no parity  3: 7 bits, even, 2 stop, 4 clk/bit
  uart_tx_frame u_def (.clk(clk), .rst(rst), .tx_data(d0), .tx_valid(v0), .tx_ready(rd0),
                       .serial_out(so0), .busy(bs0), .frame_done(fd0));
  uart_tx_frame #(.PARITY_MODE(2)) u_odd (.clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1),
                       .tx_ready(rd1), .serial_out(so1), .busy(bs1), .frame_done(fd1));
  uart_tx_frame #(.PARITY_MODE(0)) u_nop (.clk(clk), .rst(rst), .tx_data(d2), .tx_valid(v2),
                       .tx_ready(rd2), .serial_out(so2), .busy(bs2), .frame_done(fd2));
  uart_tx_frame #(.DATA_W(7), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(2)) u_w7 (
                       .clk(clk), .rst(rst), .tx_data(d3), .tx_valid(v3), .tx_ready(rd3),
                       .serial_out(so3), .busy(bs3), .frame_done(fd3));

  function automatic int p_dw(input int id);
    return (id == 3) ? 7 : 8;
  endfunction
  function automatic int p_cpb(input int id);
    return (id == 3) ? 4 : 16;
  endfunction
  function automatic int p_pm(input int id);
    case (id)
      1: return 2;
      2: return 0;
      default: return 1;
    endcase
  endfunction
  function automatic int p_sb(input int id);
    return (id == 3) ? 2 : 1;
  endfunction

  function automatic logic get_so(input int id);
    case (id) 0: return so0; 1: return so1; 2: return so2; default: return so3; endcase
  endfunction
  function automatic logic get_rdy(input int id);
    case (id) 0: return rd0; 1: return rd1; 2: return rd2; default: return rd3; endcase
  endfunction
  function automatic logic get_bsy(input int id);
    case (id) 0: return bs0; 1: return bs1; 2: return bs2; default: return bs3; endcase
  endfunction
  function automatic logic get_fd(input int id);
    case (id) 0: return fd0; 1: return fd1; 2: return fd2; default: return fd3; endcase
  endfunction

  task automatic set_valid(input int id, input logic v);
    case (id) 0: v0 = v; 1: v1 = v; 2: v2 = v; default: v3 = v; endcase
  endtask
  task automatic set_data(input int id, input logic [8:0] w);
    case (id) 0: d0 = w[7:0]; 1: d1 = w[7:0]; 2: d2 = w[7:0]; default: d3 = w[6:0]; endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for tx_ready, present the word and let the next edge accept it.
  task automatic accept_word(input int id, input logic [8:0] w, input bit keep);
    int n = 0;
    @(negedge clk);
    while (get_rdy(id) !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_accept", 32'(get_rdy(id)), 32'd1);
    set_data(id, w);
    set_valid(id, 1'b1);
    @(posedge clk);
    #1;
    if (!keep) set_valid(id, 1'b0);
  endtask

  // Called right after the accepting edge: compare every clock of the frame,
  // optionally pulse tx_valid mid-frame, then check the idle cycle after it.
  task automatic check_frame(input int id, input logic [8:0] w, input bit pulse);
    logic q[$];
    logic par;
    int   cpb, n;
    cpb = p_cpb(id);
    par = 1'b0;
    q.push_back(1'b0);
    for (int i = 0; i < p_dw(id); i++) begin
      q.push_back(w[i]);
      par = par ^ w[i];
    end
    if (p_pm(id) == 1) q.push_back(par);
    if (p_pm(id) == 2) q.push_back(~par);
    for (int i = 0; i < p_sb(id); i++) q.push_back(1'b1);
    n = q.size() * cpb;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      chk($sformatf("line id%0d k%0d", id, k), 32'(get_so(id)), 32'(q[(k - 1) / cpb]));
      chk($sformatf("done id%0d k%0d", id, k), 32'(get_fd(id)), 32'(k == n));
      chk($sformatf("busy id%0d k%0d", id, k), 32'(get_bsy(id)), 32'd1);
      chk($sformatf("ready id%0d k%0d", id, k), 32'(get_rdy(id)), 32'd0);
      if (pulse && k == 3 * cpb) begin
        set_data(id, ~w);
        set_valid(id, 1'b1);
      end
      if (pulse && k == 3 * cpb + 2) set_valid(id, 1'b0);
    end
    @(negedge clk);
    chk($sformatf("tail line id%0d", id), 32'(get_so(id)), 32'd1);
    chk($sformatf("tail ready id%0d", id), 32'(get_rdy(id)), 32'd1);
    chk($sformatf("tail busy id%0d", id), 32'(get_bsy(id)), 32'd0);
    chk($sformatf("tail done id%0d", id), 32'(get_fd(id)), 32'd0);
  endtask

  initial begin
    logic [8:0] w;
    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;

    // Reset held, then released with no valid: idle line for 50 cycles.
    repeat (3) @(negedge clk);
    for (int id = 0; id < 4; id++) begin
      chk($sformatf("rst line id%0d", id), 32'(get_so(id)), 32'd1);
      chk($sformatf("rst ready id%0d", id), 32'(get_rdy(id)), 32'd1);
    end
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      for (int id = 0; id < 4; id++) begin
        chk($sformatf("idle line id%0d", id), 32'(get_so(id)), 32'd1);
        chk($sformatf("idle ready id%0d", id), 32'(get_rdy(id)), 32'd1);
        chk($sformatf("idle busy id%0d", id), 32'(get_bsy(id)), 32'd0);
        chk($sformatf("idle done id%0d", id), 32'(get_fd(id)), 32'd0);
      end
    end

    // Directed frames for 0xAC on each configuration and 0x55 on the 7-bit one.
    accept_word(0, 9'h0AC, 1'b0); check_frame(0, 9'h0AC, 1'b0);
    accept_word(1, 9'h0AC, 1'b0); check_frame(1, 9'h0AC, 1'b0);
    accept_word(2, 9'h0AC, 1'b0); check_frame(2, 9'h0AC, 1'b0);
    accept_word(3, 9'h055, 1'b0); check_frame(3, 9'h055, 1'b0);

    // Back-to-back: valid held high, data changed after accept, second word
    // accepted in the single idle cycle after frame_done.
    accept_word(0, 9'h001, 1'b1);
    set_data(0, 9'h0FF);
    check_frame(0, 9'h001, 1'b0);
    @(posedge clk);
    #1;
    set_valid(0, 1'b0);
    check_frame(0, 9'h0FF, 1'b0);

    // A valid pulse mid-frame must not disturb the frame in flight.
    accept_word(0, 9'h05A, 1'b0); check_frame(0, 9'h05A, 1'b1);
    accept_word(3, 9'h033, 1'b0); check_frame(3, 9'h033, 1'b1);

    // Reset during data bit 3 of 0xAC: line high at once, no frame_done afterwards.
    accept_word(0, 9'h0AC, 1'b0);
    repeat (16 + 3 * 16 + 5) @(negedge clk);
    chk("pre-rst busy", 32'(bs0), 32'd1);
    chk("pre-rst line", 32'(so0), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid-rst line", 32'(so0), 32'd1);
    chk("mid-rst busy", 32'(bs0), 32'd0);
    chk("mid-rst ready", 32'(rd0), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      chk("post-rst done", 32'(fd0), 32'd0);
      chk("post-rst line", 32'(so0), 32'd1);
    end
    accept_word(0, 9'h0AC, 1'b0); check_frame(0, 9'h0AC, 1'b0);

    // Random words on every configuration.
    for (int r = 0; r < 4; r++) begin
      for (int id = 0; id < 4; id++) begin
        w = 9'($urandom_range(0, 255));
        if (id == 3) w = w & 9'h07F;
        accept_word(id, w, 1'b0);
        check_frame(id, w, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
